// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver line and result bundle: raw kclk/kdata in, scan-code history and status pulses out.
// The block never drives the PS/2 lines, so kclk/kdata are inputs on the receiver side only.
interface ps2_frame_rx_if;
    logic        kclk;
    logic        kdata;
    logic [15:0] keycode;
    logic        oflag;
    logic        perr;

    modport slave (
        input  kclk,
        input  kdata,
        output keycode,
        output oflag,
        output perr
    );

    modport master (
        output kclk,
        output kdata,
        input  keycode,
        input  oflag,
        input  perr
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: 2-FF sync + kclk glitch filter, 11-bit odd-parity frames into a 16-bit history.
// Pulses land FILTER_LEN+3 clk after the raw stop-bit kclk fall; no backpressure, keycode holds until the next good byte.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_frame_rx_if.slave bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           kclk_s1_q, kclk_s2_q;
    logic           kdata_s1_q, kdata_s2_q;
    logic           fclk_q, fclk_d, fclk_prev_q;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [15:0]    keycode_q, keycode_d;
    logic           oflag_q, oflag_d;
    logic           perr_q, perr_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           fall;
    logic           timeout_hit;
    logic           frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_s1_q   <= 1'b1;
            kclk_s2_q   <= 1'b1;
            kdata_s1_q  <= 1'b1;
            kdata_s2_q  <= 1'b1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            keycode_q   <= '0;
            oflag_q     <= 1'b0;
            perr_q      <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            kclk_s1_q   <= bus.kclk;
            kclk_s2_q   <= kclk_s1_q;
            kdata_s1_q  <= bus.kdata;
            kdata_s2_q  <= kdata_s1_q;
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            keycode_q   <= keycode_d;
            oflag_q     <= oflag_d;
            perr_q      <= perr_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // fcnt counts consecutive samples that disagree with fclk; any agreeing sample restarts it.
    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (kclk_s2_q != fclk_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                fclk_d = kclk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    assign fall        = fclk_prev_q & ~fclk_q;
    assign timeout_hit = (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
    assign frame_ok    = (^{shift_q, par_q}) & kdata_s2_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        keycode_d = keycode_q;
        oflag_d   = 1'b0;
        perr_d    = 1'b0;
        to_cnt_d  = '0;

        if (state_q != IDLE && !fall) begin
            to_cnt_d = to_cnt_q + TCW'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall && !kdata_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = kdata_s2_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = kdata_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        oflag_d   = 1'b1;
                        keycode_d = {keycode_q[7:0], shift_q};
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall in the same cycle keeps the frame alive, so the abort only fires without one.
        if (state_q != IDLE && !fall && timeout_hit) begin
            state_d  = IDLE;
            perr_d   = 1'b1;
            to_cnt_d = '0;
        end
    end

    assign bus.keycode = keycode_q;
    assign bus.oflag   = oflag_q;
    assign bus.perr    = perr_q;
endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
- PS/2 device-to-host receiver. Sits directly upstream of the keyboard key-event filter.
- Synchronises and deglitches the raw PS/2 clock/data lines, then deframes 11-bit frames (start, 8 data bits LSB-first, odd parity, stop).
- Shifts each valid byte into a 16-bit scan-code history and pulses a one-cycle flag.
- Adds parity/framing checking and a stuck-frame timeout.

Parameters:
- FILTER_LEN, 8, number of consecutive identical synchronised samples required before the filtered kclk changes level.
- TIMEOUT_CYCLES, 200000, clk cycles without a filtered kclk falling edge, while mid-frame, before the frame is aborted (2 ms at 100 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- kclk  input  1  raw PS/2 clock line, asynchronous
- kdata  input  1  raw PS/2 data line, asynchronous
- keycode  output  16  scan-code history: [15:8] previous byte, [7:0] newest byte
- oflag  output  1  one-cycle pulse, new valid byte present in keycode
- perr  output  1  one-cycle pulse, frame dropped (parity, start/stop or timeout error)

Behaviour:
- Reset values: keycode=16'h0000, oflag=0, perr=0, state=IDLE, bit counter=0, timeout counter=0, sync/filter registers=1 (idle-high bus).
- Synchronisation:
  - kclk and kdata each pass through a 2-FF synchroniser.
  - Filtered kclk (fclk) takes the synchronised value only after FILTER_LEN consecutive equal samples.
  - A sample counter resets on any change.
  - kdata is synchronised but not filtered.
- Edge: fall = fclk_q & ~fclk, a single-cycle strobe. kdata is sampled in the same cycle as fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with kdata=0 -> DATA, bit counter=0, shift reg cleared. fall with kdata=1 -> stay IDLE, no pulse.
  - DATA: on each fall, shift kdata into bit[cnt], LSB first. After the 8th bit -> PARITY.
  - PARITY: on fall, store the parity bit -> STOP.
  - STOP: on fall, evaluate and -> IDLE.
    - Valid frame: XOR(data[7:0], parity) == 1 and stop bit == 1.
    - Valid: keycode <= {keycode[7:0], data}.
    - Invalid: keycode unchanged.
- Output timing:
  - oflag is registered and asserts in the cycle after the stop-bit fall strobe, for exactly 1 cycle.
  - keycode updates in that same cycle and holds until the next valid frame.
  - perr behaves the same way on an invalid frame.
  - oflag and perr are never both high.
- Timeout:
  - The counter clears on every fall and increments each cycle while state != IDLE.
  - On reaching TIMEOUT_CYCLES-1: state -> IDLE, perr pulses next cycle, keycode unchanged.
  - The counter is held at 0 in IDLE.
- Simultaneous events: if fall and timeout occur in the same cycle, fall wins (counter clears, frame continues).
- Reset mid-frame: the partial frame is discarded, outputs return to their reset values, and no pulse is produced. The next start bit is received normally.
- Throughput: one byte per frame. No buffering; downstream must consume keycode on oflag or at any time before the next oflag.
- Only odd parity is supported. There is no host-to-device transmit; the block never drives kclk or kdata.

Test Plan:
- Reset, then a frame for 0x1C (parity 0, stop 1) at 12.5 kHz PS/2 clock -> oflag one pulse, keycode=16'h001C, perr stays 0.
- Three frames 0x1C, 0xF0, 0x1C -> three oflag pulses. keycode sequence 16'h001C, 16'h1CF0, 16'hF01C.
- Frame 0x1C with parity bit 1 -> perr one pulse, oflag 0, keycode holds 16'h001C. A following good 0x1B frame -> keycode 16'h1C1B.
- kclk low glitches of FILTER_LEN-2 cycles during IDLE and mid-frame -> no bit sampled. A valid 0x2A frame with glitches interleaved -> keycode[7:0]=8'h2A.
- Start bit plus 4 data bits, then kclk held high for TIMEOUT_CYCLES -> perr pulses exactly once, state IDLE. The next full 0x1D frame -> oflag and keycode[7:0]=8'h1D.
- rst asserted for 1 cycle after the 5th data bit -> keycode=0, no oflag or perr. The remaining bits of the aborted frame are garbage and are allowed to produce perr. After idle, a clean 0x75 frame -> keycode=16'h0075.
